// File: rtl/ppg_beat_extractor.sv
// De-interleaves RED/IR samples using the LED controller phases and tracks the IR pulse
// trough-to-trough, emitting per-beat AC/DC values and the beat period.
module ppg_beat_extractor #(
   parameter logic [7:0]  HYST       = 8'd6,
   parameter int unsigned MIN_PERIOD = 10,
   parameter int unsigned MAX_PERIOD = 100,
   parameter int unsigned PERIOD_W   = 8
) (
   input  logic                CLK,
   input  logic                rst,
   input  logic                Enable,
   input  logic                LED_RED,
   input  logic                LED_IR,
   input  logic [7:0]          RED_ADC_Value,
   input  logic [7:0]          IR_ADC_Value,
   output logic                Beat_Valid,
   output logic                Timeout,
   output logic [7:0]          RED_AC,
   output logic [7:0]          RED_DC,
   output logic [7:0]          IR_AC,
   output logic [7:0]          IR_DC,
   output logic [PERIOD_W-1:0] Beat_Period
);
   localparam int unsigned DW = 8;
   localparam int unsigned CW = PERIOD_W + 1;
   localparam logic [PERIOD_W-1:0] MAX_CNT = PERIOD_W'(MAX_PERIOD);
   localparam logic [PERIOD_W-1:0] MIN_CNT = PERIOD_W'(MIN_PERIOD);

   typedef enum logic [2:0] {IDLE, ACQ_MAX, ACQ_MIN, SEEK_MAX, SEEK_MIN} state_t;

   state_t              state, state_n;
   logic                led_red_d, led_ir_d, pair_v;
   logic [DW-1:0]       red_s, ir_s;
   logic [DW-1:0]       ir_max, ir_min, red_max, red_min;
   logic [DW-1:0]       ir_max_n, ir_min_n, red_max_n, red_min_n;
   logic [DW-1:0]       ir_max_a, ir_min_a, red_max_a, red_min_a;
   logic [PERIOD_W-1:0] cnt, cnt_n, cnt_sat;
   logic [CW-1:0]       cnt_p1;
   logic                beat_valid_n, timeout_n, restart;
   logic [DW-1:0]       red_ac_n, red_dc_n, ir_ac_n, ir_dc_n;
   logic [PERIOD_W-1:0] period_n;
   logic                red_fall_c, ir_fall_c, peak_c, trough_c;

   function automatic logic [DW-1:0] dc_of(input logic [DW-1:0] hi, input logic [DW-1:0] lo);
      return DW'(((DW+1)'(hi) + (DW+1)'(lo)) >> 1);
   endfunction

   assign red_fall_c = Enable & led_red_d & ~LED_RED;
   assign ir_fall_c  = Enable & led_ir_d & ~LED_IR;

   // Sample capture on LED phase falling edges; a pair is ready the cycle after the IR fall
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         led_red_d <= 1'b0;
         led_ir_d  <= 1'b0;
         pair_v    <= 1'b0;
         red_s     <= '0;
         ir_s      <= '0;
      end else begin
         led_red_d <= LED_RED;
         led_ir_d  <= LED_IR;
         pair_v    <= ir_fall_c;
         if (red_fall_c) red_s <= RED_ADC_Value;
         if (ir_fall_c)  ir_s  <= IR_ADC_Value;
      end
   end

   assign ir_max_a  = (ir_s > ir_max)   ? ir_s  : ir_max;
   assign ir_min_a  = (ir_s < ir_min)   ? ir_s  : ir_min;
   assign red_max_a = (red_s > red_max) ? red_s : red_max;
   assign red_min_a = (red_s < red_min) ? red_s : red_min;
   assign cnt_p1    = CW'(cnt) + CW'(1);
   assign cnt_sat   = (cnt_p1 >= CW'(MAX_PERIOD)) ? MAX_CNT : cnt_p1[PERIOD_W-1:0];
   // Hysteresis compares are one bit wider so sample+HYST never wraps
   assign peak_c    = (DW+1)'(ir_max_a) > ((DW+1)'(ir_s) + (DW+1)'(HYST));
   assign trough_c  = (DW+1)'(ir_s) > ((DW+1)'(ir_min_a) + (DW+1)'(HYST));

   always_comb begin
      state_n      = state;
      ir_max_n     = ir_max;
      ir_min_n     = ir_min;
      red_max_n    = red_max;
      red_min_n    = red_min;
      cnt_n        = cnt;
      beat_valid_n = 1'b0;
      timeout_n    = 1'b0;
      red_ac_n     = RED_AC;
      red_dc_n     = RED_DC;
      ir_ac_n      = IR_AC;
      ir_dc_n      = IR_DC;
      period_n     = Beat_Period;
      restart      = 1'b0;
      if (!Enable) begin
         state_n   = IDLE;
         ir_max_n  = '0;
         ir_min_n  = '0;
         red_max_n = '0;
         red_min_n = '0;
         cnt_n     = '0;
      end else if (pair_v) begin
         if (state == IDLE) begin
            restart = 1'b1;
            state_n = ACQ_MAX;
         end else begin
            ir_max_n  = ir_max_a;
            ir_min_n  = ir_min_a;
            red_max_n = red_max_a;
            red_min_n = red_min_a;
            cnt_n     = cnt_sat;
            if (cnt_sat == MAX_CNT) begin
               timeout_n = 1'b1;
               restart   = 1'b1;
               state_n   = ACQ_MAX;
            end else begin
               case (state)
                  ACQ_MAX, SEEK_MAX: begin
                     if (peak_c) begin
                        ir_min_n = ir_s;
                        state_n  = (state == ACQ_MAX) ? ACQ_MIN : SEEK_MIN;
                     end
                  end
                  ACQ_MIN, SEEK_MIN: begin
                     if (trough_c) begin
                        restart = 1'b1;
                        state_n = SEEK_MAX;
                        // The acquisition trough only arms; short beats are noise
                        if (state == SEEK_MIN && cnt_sat >= MIN_CNT) begin
                           beat_valid_n = 1'b1;
                           period_n     = cnt_sat;
                           ir_ac_n      = ir_max_a - ir_min_a;
                           ir_dc_n      = dc_of(ir_max_a, ir_min_a);
                           red_ac_n     = red_max_a - red_min_a;
                           red_dc_n     = dc_of(red_max_a, red_min_a);
                        end
                     end
                  end
                  default: state_n = IDLE;
               endcase
            end
         end
      end
      if (restart) begin
         ir_max_n  = ir_s;
         ir_min_n  = ir_s;
         red_max_n = red_s;
         red_min_n = red_s;
         cnt_n     = '0;
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ir_max      <= '0;
         ir_min      <= '0;
         red_max     <= '0;
         red_min     <= '0;
         cnt         <= '0;
         Beat_Valid  <= 1'b0;
         Timeout     <= 1'b0;
         RED_AC      <= '0;
         RED_DC      <= '0;
         IR_AC       <= '0;
         IR_DC       <= '0;
         Beat_Period <= '0;
      end else begin
         state       <= state_n;
         ir_max      <= ir_max_n;
         ir_min      <= ir_min_n;
         red_max     <= red_max_n;
         red_min     <= red_min_n;
         cnt         <= cnt_n;
         Beat_Valid  <= beat_valid_n;
         Timeout     <= timeout_n;
         RED_AC      <= red_ac_n;
         RED_DC      <= red_dc_n;
         IR_AC       <= ir_ac_n;
         IR_DC       <= ir_dc_n;
         Beat_Period <= period_n;
      end
   end
endmodule

// File: tb/tb_ppg_beat_extractor.sv
// Bench for ppg_beat_extractor: table-driven triangle beats, directed corner sequences and
// randomized waveforms checked cycle by cycle against a window-based beat model.
module tb_ppg_beat_extractor;
   localparam int HYST  = 6;
   localparam int MIN_P = 10;
   localparam int MAX_P = 100;

   logic       CLK = 1'b0;
   logic       rst;
   logic       Enable;
   logic       LED_RED, LED_IR;
   logic [7:0] RED_ADC_Value, IR_ADC_Value;
   logic       Beat_Valid, Timeout;
   logic [7:0] RED_AC, RED_DC, IR_AC, IR_DC;
   logic [7:0] Beat_Period;

   ppg_beat_extractor dut (
      .CLK(CLK), .rst(rst), .Enable(Enable), .LED_RED(LED_RED), .LED_IR(LED_IR),
      .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
      .Beat_Valid(Beat_Valid), .Timeout(Timeout), .RED_AC(RED_AC), .RED_DC(RED_DC),
      .IR_AC(IR_AC), .IR_DC(IR_DC), .Beat_Period(Beat_Period)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0, n_bad = 0;
   int n_beats, n_tos, l_per, l_iac, l_idc, l_rac, l_rdc;

   // Capture shadow and expected outputs
   bit         p_red, p_ir, pend;
   int         c_red, c_ir;
   logic       e_bv, e_to;
   logic [7:0] e_rac, e_rdc, e_iac, e_idc, e_per;

   // Beat model: sample history since the window restart, plus phase flags
   bit m_active, m_acq, m_want_trough;
   int q_ir[$], q_red[$];
   int m_min_from;

   function automatic int qmax(input int q[$], input int from);
      int m;
      m = q[from];
      for (int j = from + 1; j < q.size(); j++) if (q[j] > m) m = q[j];
      return m;
   endfunction

   function automatic int qmin(input int q[$], input int from);
      int m;
      m = q[from];
      for (int j = from + 1; j < q.size(); j++) if (q[j] < m) m = q[j];
      return m;
   endfunction

   function automatic void m_restart(input int r, input int i);
      q_ir.delete(); q_red.delete();
      q_ir.push_back(i); q_red.push_back(r);
      m_min_from = 0;
   endfunction

   function automatic void model_pair(input int r, input int i);
      int n, imx, imn, rmx, rmn;
      if (!m_active) begin
         m_active = 1; m_acq = 1; m_want_trough = 0;
         m_restart(r, i);
         return;
      end
      q_ir.push_back(i); q_red.push_back(r);
      n = q_ir.size() - 1;
      if (n >= MAX_P) begin
         e_to = 1; m_acq = 1; m_want_trough = 0;
         m_restart(r, i);
      end else if (!m_want_trough) begin
         if (qmax(q_ir, 0) > i + HYST) begin
            m_want_trough = 1;
            m_min_from = q_ir.size() - 1;
         end
      end else if (i > qmin(q_ir, m_min_from) + HYST) begin
         if (!m_acq && n >= MIN_P) begin
            imx = qmax(q_ir, 0); imn = qmin(q_ir, m_min_from);
            rmx = qmax(q_red, 0); rmn = qmin(q_red, 0);
            e_bv = 1; e_per = 8'(n);
            e_iac = 8'(imx - imn); e_idc = 8'((imx + imn) / 2);
            e_rac = 8'(rmx - rmn); e_rdc = 8'((rmx + rmn) / 2);
         end
         m_acq = 0; m_want_trough = 0;
         m_restart(r, i);
      end
   endfunction

   function automatic void reset_shadow();
      p_red = 0; p_ir = 0; pend = 0; c_red = 0; c_ir = 0;
      e_bv = 0; e_to = 0; e_rac = 0; e_rdc = 0; e_iac = 0; e_idc = 0; e_per = 0;
      m_active = 0; m_acq = 0; m_want_trough = 0;
      q_ir.delete(); q_red.delete(); m_min_from = 0;
   endfunction

   // Advance the shadow by one clock edge using the inputs held during the ending cycle
   function automatic void model_edge();
      if (rst) begin reset_shadow(); return; end
      e_bv = 0; e_to = 0;
      if (!Enable) m_active = 0;
      else if (pend) model_pair(c_red, c_ir);
      if (Enable && p_red && !LED_RED) c_red = int'(RED_ADC_Value);
      pend = Enable && p_ir && !LED_IR;
      if (pend) c_ir = int'(IR_ADC_Value);
      p_red = LED_RED; p_ir = LED_IR;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      n_vec++;
      if (Beat_Valid !== e_bv || Timeout !== e_to || RED_AC !== e_rac || RED_DC !== e_rdc ||
          IR_AC !== e_iac || IR_DC !== e_idc || Beat_Period !== e_per) begin
         n_bad++;
         $display("FAIL cycle_outputs t=%0t: got bv=%0b to=%0b rac=%0d rdc=%0d iac=%0d idc=%0d per=%0d; expected bv=%0b to=%0b rac=%0d rdc=%0d iac=%0d idc=%0d per=%0d",
                  $time, Beat_Valid, Timeout, RED_AC, RED_DC, IR_AC, IR_DC, Beat_Period,
                  e_bv, e_to, e_rac, e_rdc, e_iac, e_idc, e_per);
      end
      if (Beat_Valid === 1'b1) begin
         n_beats++;
         l_per = int'(Beat_Period); l_iac = int'(IR_AC); l_idc = int'(IR_DC);
         l_rac = int'(RED_AC); l_rdc = int'(RED_DC);
      end
      if (Timeout === 1'b1) n_tos++;
   endtask

   function automatic int outs_nonzero();
      return int'(Beat_Valid) + int'(Timeout) + int'(RED_AC != 0) + int'(RED_DC != 0) +
             int'(IR_AC != 0) + int'(IR_DC != 0) + int'(Beat_Period != 0);
   endfunction

   // One controller sample pair: RED phase, IR phase, dark phase (or both LEDs together)
   task automatic drive_pair(input int red, input int ir, input int len, input bit both);
      RED_ADC_Value = 8'(red);
      IR_ADC_Value  = 8'(ir);
      if (both) begin
         LED_RED = 1; LED_IR = 1; repeat (len) step();
         LED_RED = 0; LED_IR = 0; repeat (len + 1) step();
      end else begin
         LED_RED = 1; repeat (len) step();
         LED_RED = 0; LED_IR = 1; repeat (len) step();
         LED_IR = 0; repeat (len + 1) step();
      end
   endtask

   task automatic do_reset();
      rst = 1; Enable = 0; LED_RED = 0; LED_IR = 0; RED_ADC_Value = 0; IR_ADC_Value = 0;
      reset_shadow();
      repeat (3) step();
      rst = 0;
      step();
      n_beats = 0; n_tos = 0;
      l_per = -1; l_iac = -1; l_idc = -1; l_rac = -1; l_rdc = -1;
   endtask

   function automatic int tri_val(input int lo, input int stp, input int half, input int k);
      int ph;
      ph = k % (2 * half);
      return (ph <= half) ? lo + stp * ph : lo + stp * (2 * half - ph);
   endfunction

   typedef struct {
      int ir_lo, ir_step, red_lo, red_step, half, len;
      bit both;
      int beats, per, iac, idc, rac, rdc;
   } row_t;

   row_t rows[3];
   int   ripple[4];
   int   spike[6];

   initial begin
      int ir, dir, run, stp, P;
      rows[0] = '{100, 4, 110, 2, 20, 10, 1'b0, 3, 40, 80, 140, 40, 130};
      rows[1] = '{0, 17, 0, 17, 15, 2, 1'b1, 3, 30, 255, 127, 255, 127};
      rows[2] = '{50, 6, 90, 0, 10, 3, 1'b0, 3, 20, 60, 80, 0, 90};
      ripple  = '{125, 128, 131, 128};
      spike   = '{112, 116, 120, 100, 100, 115};

      // Reset state, then LEDs toggling while disabled
      do_reset();
      check("reset_outputs_zero", outs_nonzero(), 0);
      for (int k = 0; k < 6; k++) drive_pair(50 + 30 * k, 200 - 30 * k, 2, k[0]);
      check("disabled_no_beat", n_beats, 0);
      check("disabled_no_timeout", n_tos, 0);
      check("disabled_outputs_zero", outs_nonzero(), 0);

      // Table of clean triangle waveforms with hand-derived beat results
      for (int r = 0; r < 3; r++) begin
         do_reset();
         Enable = 1;
         P = 2 * rows[r].half;
         for (int k = 0; k < 4 * P + 6; k++)
            drive_pair(tri_val(rows[r].red_lo, rows[r].red_step, rows[r].half, k),
                       tri_val(rows[r].ir_lo, rows[r].ir_step, rows[r].half, k),
                       rows[r].len, rows[r].both);
         repeat (3) step();
         check($sformatf("row%0d_beats", r), n_beats, rows[r].beats);
         check($sformatf("row%0d_period", r), l_per, rows[r].per);
         check($sformatf("row%0d_ir_ac", r), l_iac, rows[r].iac);
         check($sformatf("row%0d_ir_dc", r), l_idc, rows[r].idc);
         check($sformatf("row%0d_red_ac", r), l_rac, rows[r].rac);
         check($sformatf("row%0d_red_dc", r), l_rdc, rows[r].rdc);
         check($sformatf("row%0d_timeouts", r), n_tos, 0);
      end

      // Ripple whose peak-to-peak equals HYST: timeouts only, every 100 pairs
      do_reset();
      Enable = 1;
      for (int k = 0; k < 250; k++) drive_pair(100, ripple[k % 4], 1, 1'b0);
      repeat (3) step();
      check("ripple_timeouts", n_tos, 2);
      check("ripple_no_beat", n_beats, 0);

      // Short spike trough is rejected; next period counts from the spike trough
      do_reset();
      Enable = 1;
      for (int k = 0; k <= 82; k++) drive_pair(130, tri_val(100, 4, 20, k), 2, 1'b0);
      check("spike_first_beat", n_beats, 1);
      check("spike_first_period", l_per, 40);
      for (int k = 0; k < 6; k++) drive_pair(130, spike[k], 2, 1'b0);
      repeat (3) step();
      check("spike_rejected", n_beats, 1);
      for (int k = 124; k <= 162; k++) drive_pair(130, tri_val(100, 4, 20, k), 2, 1'b0);
      repeat (3) step();
      check("spike_next_beat", n_beats, 2);
      check("spike_next_period", l_per, 39);
      check("spike_next_ir_ac", l_iac, 80);
      check("spike_next_ir_dc", l_idc, 140);

      // Enable drop mid-beat holds outputs; re-enable re-acquires
      do_reset();
      Enable = 1;
      for (int k = 0; k <= 100; k++) drive_pair(130, tri_val(100, 4, 20, k), 2, 1'b0);
      check("drop_beat_before", n_beats, 1);
      Enable = 0;
      repeat (20) step();
      check("drop_hold_ir_ac", int'(IR_AC), 80);
      check("drop_hold_period", int'(Beat_Period), 40);
      check("drop_no_strobe", n_beats + n_tos, 1);
      Enable = 1;
      n_beats = 0;
      for (int k = 10; k <= 60; k++) drive_pair(130, tri_val(100, 4, 20, k), 2, 1'b0);
      repeat (3) step();
      check("reenable_acq_no_strobe", n_beats, 0);
      for (int k = 61; k <= 90; k++) drive_pair(130, tri_val(100, 4, 20, k), 2, 1'b0);
      repeat (3) step();
      check("reenable_beat", n_beats, 1);
      check("reenable_period", l_per, 40);

      // Async reset while hunting for a trough
      do_reset();
      Enable = 1;
      for (int k = 0; k <= 110; k++) drive_pair(130, tri_val(100, 4, 20, k), 2, 1'b0);
      check("rst_pre_outputs_set", int'(outs_nonzero() > 0), 1);
      @(negedge CLK);
      rst = 1;
      reset_shadow();
      #1;
      check("rst_async_clear", outs_nonzero(), 0);
      repeat (2) step();
      rst = 0;
      n_beats = 0;
      for (int k = 0; k <= 45; k++) drive_pair(130, tri_val(100, 4, 20, k), 2, 1'b0);
      repeat (3) step();
      check("rst_acq_no_strobe", n_beats, 0);
      for (int k = 46; k <= 85; k++) drive_pair(130, tri_val(100, 4, 20, k), 2, 1'b0);
      repeat (3) step();
      check("rst_resume_beat", n_beats, 1);

      // Randomized wandering waveform with occasional enable drops
      do_reset();
      Enable = 1;
      ir = 128; dir = 1; run = 0; stp = 1;
      for (int k = 0; k < 1500; k++) begin
         if (run == 0) begin
            dir = -dir;
            run = int'($urandom_range(3, 30));
            stp = int'($urandom_range(0, 9));
         end
         ir = ir + dir * stp + int'($urandom_range(0, 4)) - 2;
         if ($urandom_range(0, 99) == 0) ir = int'($urandom_range(0, 255));
         if (ir < 0) ir = 0;
         if (ir > 255) ir = 255;
         run--;
         drive_pair(int'($urandom_range(0, 255)), ir, int'($urandom_range(1, 3)),
                    $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 199) == 0) begin
            Enable = 0;
            repeat (int'($urandom_range(1, 10))) step();
            Enable = 1;
         end
      end
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
